// File: rtl/cbm_lp_pkg.sv
// Shared link-layer defines: 8b/10b K-characters, fixed word bytes, framer states and CRC constants.
package cbm_lp_pkg;

   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K27_7 = 8'hFB;
   localparam logic [7:0] K29_7 = 8'hFD;
   localparam logic [7:0] K30_7 = 8'hFE;
   localparam logic [7:0] K28_6 = 8'hDC;

   // Upper bytes of the idle and SOF words (sent second on the wire)
   localparam logic [7:0] IDLE_HI = 8'h50;
   localparam logic [7:0] SOF_HI  = 8'h01;

   localparam logic [15:0] CRC_INIT = 16'hFFFF;
   localparam logic [15:0] CRC_POLY = 16'h1021;

   typedef enum logic [2:0] {
      IDLE, SOF, PAY, CRC, EOF, DLM, ABORT
   } lp_state_t;

endpackage

// File: rtl/lp_crc16_16b.sv
// One-word CRC-16 step: poly 0x1021, MSB-first, data bit 15 enters first.
module lp_crc16_16b
   import cbm_lp_pkg::*;
(
   input  logic [15:0] data,
   input  logic [15:0] crc,
   output logic [15:0] crc_next
);

   logic [15:0] c;

   always_comb begin
      c = crc;
      for (int i = 15; i >= 0; i--) begin
         if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
         else                 c = {c[14:0], 1'b0};
      end
      crc_next = c;
   end

endmodule

// File: rtl/lp_tx_framer.sv
// Link TX framer: wraps source words as SOF / payload / CRC / EOF, interleaves DLMs and idles,
// and aborts the frame when the link drops.
module lp_tx_framer
   import cbm_lp_pkg::*;
#(
   parameter logic [7:0] ALIGN_CHAR = K28_5,
   parameter logic [7:0] SOF_CHAR   = K27_7,
   parameter logic [7:0] EOF_CHAR   = K29_7,
   parameter logic [7:0] ABORT_CHAR = K30_7,
   parameter logic [7:0] DLM_CHAR   = K28_6
) (
   input  logic        clk,
   input  logic        res,
   input  logic        link_active,
   input  logic        data2send_start,
   input  logic        data2send_end,
   input  logic [15:0] data2send,
   output logic        data2send_stop,
   input  logic        dlm2send_valid,
   input  logic [3:0]  dlm2send,
   output logic [15:0] tx_data,
   output logic [1:0]  tx_charisk
);

   lp_state_t   state, state_nx;
   logic [15:0] data_nx, hold, crc_q, crc_nx, crc_step, crc_din;
   logic [1:0]  k_nx;
   logic [3:0]  pend_type;
   logic        hold_end, last, last_nx, discard, discard_nx;
   logic        pend, run, idle_rdy, take_start, dlm_sent;

   // The SOF cycle folds in the held first word; PAY cycles fold in the live source word.
   assign crc_din = (state == SOF) ? hold : data2send;

   lp_crc16_16b u_crc (
      .data     (crc_din),
      .crc      (crc_q),
      .crc_next (crc_step)
   );

   // stop decodes registered state; only the IDLE qualification follows link_active in the same
   // cycle, so a start is never taken on a dead link. 'run' keeps stop high through reset.
   assign idle_rdy       = run && (state == IDLE) && link_active && !pend && !discard;
   assign data2send_stop = !(run && (discard || (state == PAY && !last) || idle_rdy));

   always_comb begin
      state_nx   = state;
      data_nx    = {IDLE_HI, ALIGN_CHAR};
      k_nx       = 2'b01;
      crc_nx     = crc_q;
      last_nx    = last;
      discard_nx = discard;
      take_start = 1'b0;
      dlm_sent   = 1'b0;

      if (discard && data2send_end) discard_nx = 1'b0;

      case (state)
         IDLE: begin
            if (pend) begin
               state_nx = DLM;
               data_nx  = {4'h0, pend_type, DLM_CHAR};
               dlm_sent = 1'b1;
            end else if (idle_rdy && data2send_start) begin
               state_nx   = SOF;
               data_nx    = {SOF_HI, SOF_CHAR};
               crc_nx     = CRC_INIT;
               take_start = 1'b1;
            end
         end
         SOF: begin
            if (!link_active) begin
               state_nx   = ABORT;
               data_nx    = {ABORT_CHAR, ABORT_CHAR};
               k_nx       = 2'b11;
               discard_nx = !hold_end;
            end else begin
               state_nx = PAY;
               data_nx  = hold;
               k_nx     = 2'b00;
               crc_nx   = crc_step;
               last_nx  = hold_end;
            end
         end
         PAY: begin
            if (!link_active) begin
               // Any word taken this cycle is dropped; keep draining unless it closed the frame.
               state_nx   = ABORT;
               data_nx    = {ABORT_CHAR, ABORT_CHAR};
               k_nx       = 2'b11;
               last_nx    = 1'b0;
               discard_nx = !last && !data2send_end;
            end else if (last) begin
               state_nx = CRC;
               data_nx  = crc_q;
               k_nx     = 2'b00;
               last_nx  = 1'b0;
            end else begin
               data_nx = data2send;
               k_nx    = 2'b00;
               crc_nx  = crc_step;
               last_nx = data2send_end;
            end
         end
         CRC: begin
            state_nx = EOF;
            data_nx  = {EOF_CHAR, EOF_CHAR};
            k_nx     = 2'b11;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state      <= IDLE;
         tx_data    <= {IDLE_HI, ALIGN_CHAR};
         tx_charisk <= 2'b01;
         crc_q      <= CRC_INIT;
         pend       <= 1'b0;
         pend_type  <= 4'h0;
         discard    <= 1'b0;
         last       <= 1'b0;
         hold       <= 16'h0000;
         hold_end   <= 1'b0;
         run        <= 1'b0;
      end else begin
         state      <= state_nx;
         tx_data    <= data_nx;
         tx_charisk <= k_nx;
         crc_q      <= crc_nx;
         discard    <= discard_nx;
         last       <= last_nx;
         run        <= 1'b1;
         if (take_start) begin
            hold     <= data2send;
            hold_end <= data2send_end;
         end
         // A fresh request wins over the clear from sending the previous one
         if (dlm2send_valid) begin
            pend      <= 1'b1;
            pend_type <= dlm2send;
         end else if (dlm_sent) begin
            pend <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lp_tx_framer.sv
// Directed bench for lp_tx_framer: idle, frames, DLM insertion, link-drop abort, mid-frame reset.
module tb_lp_tx_framer;

   logic        clk = 1'b0;
   logic        res = 1'b1;
   logic        link_active = 1'b1;
   logic        data2send_start = 1'b0;
   logic        data2send_end = 1'b0;
   logic [15:0] data2send = 16'h0000;
   logic        data2send_stop;
   logic        dlm2send_valid = 1'b0;
   logic [3:0]  dlm2send = 4'h0;
   logic [15:0] tx_data;
   logic [1:0]  tx_charisk;

   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lp_tx_framer dut (
      .clk             (clk),
      .res             (res),
      .link_active     (link_active),
      .data2send_start (data2send_start),
      .data2send_end   (data2send_end),
      .data2send       (data2send),
      .data2send_stop  (data2send_stop),
      .dlm2send_valid  (dlm2send_valid),
      .dlm2send        (dlm2send),
      .tx_data         (tx_data),
      .tx_charisk      (tx_charisk)
   );

   function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic [15:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 15; i >= 0; i--) begin
         if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
         else              r = {r[14:0], 1'b0};
      end
      return r;
   endfunction

   function automatic logic [15:0] crc_words(input int n, input logic [15:0] w0);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 0; i < n; i++) c = crc_bit(c, w0 + 16'(i));
      return c;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic chk_word(input string tag, input logic [15:0] d, input logic [1:0] k);
      chk({tag, ".data"}, tx_data, d);
      chk({tag, ".k"}, {14'b0, tx_charisk}, {14'b0, k});
   endtask

   task automatic chk_stop(input string tag, input logic exp);
      #1;
      chk({tag, ".stop"}, {15'b0, data2send_stop}, {15'b0, exp});
   endtask

   // Entered in an IDLE cycle with stop low; returns in the EOF cycle. Words are w0, w0+1, ...
   task automatic frame(input int n, input logic [15:0] w0, input logic [15:0] exp_crc,
                        input bit with_dlm);
      data2send_start = 1'b1;
      data2send       = w0;
      data2send_end   = (n == 1);
      chk_stop("f.start", 1'b0);
      cyc();
      data2send_start = 1'b0;
      data2send       = w0 + 16'd1;
      data2send_end   = (n == 2);
      chk_word("f.sof", 16'h01FB, 2'b01);
      chk_stop("f.sof", 1'b1);
      for (int i = 0; i < n; i++) begin
         cyc();
         data2send     = w0 + 16'(i + 1);
         data2send_end = (i + 1 == n - 1);
         if (with_dlm && i < 2) begin
            dlm2send_valid = 1'b1;
            dlm2send       = (i == 0) ? 4'h3 : 4'h5;
         end else begin
            dlm2send_valid = 1'b0;
         end
         chk_word("f.pay", w0 + 16'(i), 2'b00);
         chk_stop("f.pay", i == n - 1);
      end
      data2send_end  = 1'b0;
      dlm2send_valid = 1'b0;
      cyc();
      chk_word("f.crc", exp_crc, 2'b00);
      chk_stop("f.crc", 1'b1);
      cyc();
      chk_word("f.eof", 16'hFDFD, 2'b11);
      chk_stop("f.eof", 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      cyc();
      chk_word("rst", 16'h50BC, 2'b01);
      chk_stop("rst", 1'b1);
      res = 1'b0;
      repeat (3) begin
         cyc();
         chk_word("idle", 16'h50BC, 2'b01);
         chk_stop("idle", 1'b0);
      end

      // End without start in IDLE is ignored
      data2send_end = 1'b1;
      cyc();
      data2send_end = 1'b0;
      chk_word("lone_end", 16'h50BC, 2'b01);
      chk_stop("lone_end", 1'b0);

      // No start on a dead link
      link_active = 1'b0;
      data2send_start = 1'b1;
      chk_stop("nolink", 1'b1);
      cyc();
      data2send_start = 1'b0;
      link_active = 1'b1;
      chk_word("nolink", 16'h50BC, 2'b01);
      chk_stop("nolink_up", 1'b0);

      // Single-word frame of zero: CRC from 0xFFFF over 16 zero bits
      frame(1, 16'h0000, 16'h1D0F, 1'b0);
      cyc();
      chk_word("f1.idle", 16'h50BC, 2'b01);
      chk_stop("f1.idle", 1'b0);

      // Four-word frame 1..4
      frame(4, 16'h0001, crc_words(4, 16'h0001), 1'b0);
      cyc();
      chk_word("f4.idle", 16'h50BC, 2'b01);
      chk_stop("f4.idle", 1'b0);

      // DLM 3 then 5 during a frame: only type 5 goes out, once, after EOF
      frame(4, 16'h0100, crc_words(4, 16'h0100), 1'b1);
      cyc();
      chk_word("dlm.gap", 16'h50BC, 2'b01);
      chk_stop("dlm.gap", 1'b1);
      cyc();
      chk_word("dlm.word", 16'h05DC, 2'b01);
      chk_stop("dlm.word", 1'b1);
      cyc();
      chk_word("dlm.after", 16'h50BC, 2'b01);
      chk_stop("dlm.after", 1'b0);
      frame(2, 16'h0200, crc_words(2, 16'h0200), 1'b0);
      cyc();
      chk_word("f2.idle", 16'h50BC, 2'b01);

      // Link drops while word 2 of 6 is presented
      data2send_start = 1'b1;
      data2send = 16'h0010;
      chk_stop("ab.start", 1'b0);
      cyc();
      data2send_start = 1'b0;
      data2send = 16'h0011;
      chk_word("ab.sof", 16'h01FB, 2'b01);
      cyc();
      chk_word("ab.w0", 16'h0010, 2'b00);
      cyc();
      chk_word("ab.w1", 16'h0011, 2'b00);
      data2send = 16'h0012;
      link_active = 1'b0;
      chk_stop("ab.w2", 1'b0);
      cyc();
      chk_word("ab.abort", 16'hFEFE, 2'b11);
      data2send = 16'h0013;
      chk_stop("ab.w3", 1'b0);
      cyc();
      chk_word("ab.idle3", 16'h50BC, 2'b01);
      data2send = 16'h0014;
      chk_stop("ab.w4", 1'b0);
      cyc();
      chk_word("ab.idle4", 16'h50BC, 2'b01);
      data2send = 16'h0015;
      data2send_end = 1'b1;
      chk_stop("ab.w5", 1'b0);
      cyc();
      data2send_end = 1'b0;
      data2send = 16'h0000;
      chk_word("ab.idle5", 16'h50BC, 2'b01);
      chk_stop("ab.drained", 1'b1);
      link_active = 1'b1;
      chk_stop("ab.relink", 1'b0);

      // Reset pulse mid-payload: idle next, no EOF, CRC restarts
      data2send_start = 1'b1;
      data2send = 16'h00A0;
      cyc();
      data2send_start = 1'b0;
      data2send = 16'h00A1;
      chk_word("rp.sof", 16'h01FB, 2'b01);
      cyc();
      chk_word("rp.w0", 16'h00A0, 2'b00);
      res = 1'b1;
      #1;
      chk_word("rp.inrst", 16'h50BC, 2'b01);
      chk_stop("rp.inrst", 1'b1);
      res = 1'b0;
      data2send = 16'h0000;
      repeat (3) begin
         cyc();
         chk_word("rp.idle", 16'h50BC, 2'b01);
         chk_stop("rp.idle", 1'b0);
      end
      frame(1, 16'h0000, 16'h1D0F, 1'b0);
      cyc();
      chk_word("rp.end", 16'h50BC, 2'b01);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/lp_tx_framer.md
LP_TX_FRAMER -- requirements
Module: lp_tx_framer

Interface
REQ-001 SHALL have parameters: ALIGN_CHAR, default 8'hBC (K28.5), idle-word low byte; SOF_CHAR, default 8'hFB (K27.7); EOF_CHAR, default 8'hFD (K29.7); ABORT_CHAR, default 8'hFE (K30.7); DLM_CHAR, default 8'hDC (K28.6).
REQ-002 SHALL have ports:
- clk  in  1  single clock, all logic on rising edge.
- res  in  1  asynchronous, active-high reset.
- link_active  in  1  link trained; frames may start only when high.
- data2send_start  in  1  first word of frame.
- data2send_end  in  1  last word of frame.
- data2send  in  16  payload word.
- data2send_stop  out  1  backpressure; a word transfers on each cycle with stop low while the source presents a frame.
- dlm2send_valid  in  1  one-cycle DLM request.
- dlm2send  in  4  DLM type.
- tx_data  out  16  link word; byte [7:0] is sent first.
- tx_charisk  out  2  per-byte K flag; bit0 covers [7:0].

Function
REQ-003 Outputs SHALL be registered.
REQ-004 States SHALL be IDLE, SOF, PAY, CRC, EOF, DLM, ABORT.
REQ-005 Idle word SHALL be tx_data={8'h50,ALIGN_CHAR}, tx_charisk=2'b01.
REQ-006 In IDLE, data2send_stop SHALL be low only when link_active=1 and no DLM is pending.
REQ-007 Start accepted at cycle N:
- SOF word {8'h01,SOF_CHAR}/2'b01 at N+1; stop high at N+1.
- word0 from a hold register at N+2.
- Later words accepted at cycle k appear at k+1.
REQ-008 End word accepted at cycle M:
- word at M+1.
- CRC word at M+2: tx_data=crc[15:0], charisk 2'b00.
- EOF word {EOF_CHAR,EOF_CHAR}/2'b11 at M+3.
- Return to IDLE; stop high M+1..M+3.
REQ-009 If start and end are asserted in the same cycle N, the frame SHALL be one word: SOF N+1, word N+2, CRC N+3, EOF N+4.
REQ-010 CRC SHALL be CRC-16 poly 0x1021, init 0xFFFF, MSB-first, over payload words only, re-initialised at each SOF.
REQ-011 DLM request handling:
- dlm2send_valid SHALL load a one-deep pending register.
- A new request while one is pending SHALL overwrite it (latest wins).
- A DLM is sent only from IDLE, with priority over a new frame start.
- DLM word is {4'h0,dlm2send_latched,DLM_CHAR}/2'b01, one cycle; pending then clears.
- A DLM never interrupts a frame.
REQ-012 If link_active falls during SOF or PAY:
- Next word SHALL be {ABORT_CHAR,ABORT_CHAR}/2'b11, then IDLE.
- Remaining source words until end SHALL be accepted (stop low) and discarded.
REQ-013 A start seen in PAY without a preceding end SHALL be treated as a data word.
REQ-014 In IDLE, any data2send_end without a start SHALL be ignored.

Reset
REQ-015 While res=1, the block SHALL hold:
- State IDLE.
- tx_data=16'h50BC, tx_charisk=2'b01.
- data2send_stop=1.
- DLM pending cleared.
- CRC=16'hFFFF.
- Discard flag cleared.
REQ-016 Reset asserted mid-frame SHALL abandon the frame with no EOF or ABORT; idle words are output from the first cycle after release.

Structure
REQ-017 K-character constants and state encodings SHALL live in the shared cbm_lp defines package.
REQ-018 The CRC step SHALL be a sub-module lp_crc16_16b: combinational next-CRC from 16-bit data and current CRC.

Verification
REQ-019 Reset released, link_active=1, no traffic -> tx_data=16'h50BC, tx_charisk=2'b01 every cycle.
REQ-020 Single-word frame of 16'h0000 -> SOF 16'h01FB/01, 16'h0000/00, CRC 16'h1D0F/00, EOF 16'hFDFD/11, then idle.
REQ-021 Four-word frame 1,2,3,4 with stop obeyed -> consecutive words:
- Checked against a bit-serial CRC model.
- stop high exactly at SOF, CRC, EOF and end+1 cycles.
REQ-022 dlm2send_valid with type 4'h3, then 4'h5 while pending, during a frame -> exactly one word 16'h05DC/01 after EOF, before the next SOF.
REQ-023 link_active dropped during word 2 of 6 -> 16'hFEFE/11 next cycle, then idle; the remaining source words are drained with stop low.
REQ-024 res pulsed during PAY -> idle word next cycle, no EOF; the next frame's CRC starts from 0xFFFF.
